serial_shares_words_sequencer: RTL and testbench

//  Generates the (share_idx, word_idx) sequence for serial transfer of a d-share masked state.

---
 rtl/serial_shares_words_sequencer_if.sv | 24 ++
 rtl/serial_shares_words_sequencer.sv | 125 ++++++++++++
 tb/tb_serial_shares_words_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_shares_words_sequencer_if.sv
// Output stream of the share/word sequencer: one index pair per valid/ready transfer.
// A transfer happens on a rising edge where out_valid & out_ready; the master holds the pair and flags stable until then.
interface serial_shares_words_sequencer_if #(
    parameter int NBITS = 4
);
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] share_idx;
    logic [NBITS-1:0] word_idx;
    logic             first;
    logic             last_word;
    logic             last_share;
    logic             last;

    modport master (
        output out_valid, share_idx, word_idx, first, last_word, last_share, last,
        input  out_ready
    );

    modport slave (
        input  out_valid, share_idx, word_idx, first, last_word, last_share, last,
        output out_ready
    );
endinterface

// File: rtl/serial_shares_words_sequencer.sv
// Walks the (share_idx, word_idx) space of a d-share masked state in share-major or word-major order,
// offering one pair per handshake and pulsing done after the final pair is taken.
module serial_shares_words_sequencer #(
    parameter int NBITS               = 4,
    parameter int MAX_WORDS_PER_SHARE = 8,
    parameter int d                   = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [NBITS-1:0]                      words_per_share_bound,
    input  logic                                  word_major,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  dbg_state,
    serial_shares_words_sequencer_if.master       out_if
);
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [NBITS-1:0] MAX_B      = NBITS'(MAX_WORDS_PER_SHARE - 1);
    localparam logic [NBITS-1:0] LAST_SHARE = NBITS'(d - 1);

    state_t           state_q, state_n;
    logic [NBITS-1:0] share_q, share_n;
    logic [NBITS-1:0] word_q, word_n;
    logic [NBITS-1:0] b_q, b_n;
    logic             wm_q, wm_n;
    logic             done_q, done_n;

    logic             valid_c;
    logic             last_word_c;
    logic             last_share_c;
    logic             last_c;
    logic             xfer;
    logic [NBITS-1:0] bound_clamped;

    assign bound_clamped = (words_per_share_bound > MAX_B) ? MAX_B : words_per_share_bound;

    assign valid_c      = (state_q == ST_RUN);
    assign last_word_c  = valid_c && (word_q == b_q);
    assign last_share_c = valid_c && (share_q == LAST_SHARE);
    // Both orderings end on (d-1, B), so the final pair is the same test either way.
    assign last_c       = last_word_c && last_share_c;
    assign xfer         = valid_c && out_if.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            share_q <= '0;
            word_q  <= '0;
            b_q     <= '0;
            wm_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            share_q <= share_n;
            word_q  <= word_n;
            b_q     <= b_n;
            wm_q    <= wm_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        share_n = share_q;
        word_n  = word_q;
        b_n     = b_q;
        wm_n    = wm_q;
        done_n  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_n = ST_RUN;
                    b_n     = bound_clamped;
                    wm_n    = word_major;
                    share_n = '0;
                    word_n  = '0;
                end
            end
            ST_RUN: begin
                // abort wins over a transfer in the same cycle and suppresses done.
                if (abort) begin
                    state_n = ST_IDLE;
                    share_n = '0;
                    word_n  = '0;
                end else if (xfer) begin
                    if (last_c) begin
                        state_n = ST_IDLE;
                        share_n = '0;
                        word_n  = '0;
                        done_n  = 1'b1;
                    end else if (!wm_q) begin
                        if (word_q < b_q) begin
                            word_n = word_q + NBITS'(1);
                        end else begin
                            word_n  = '0;
                            share_n = share_q + NBITS'(1);
                        end
                    end else begin
                        if (share_q < LAST_SHARE) begin
                            share_n = share_q + NBITS'(1);
                        end else begin
                            share_n = '0;
                            word_n  = word_q + NBITS'(1);
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy              = valid_c;
    assign done              = done_q;
    assign dbg_state         = state_q;
    assign out_if.out_valid  = valid_c;
    assign out_if.share_idx  = share_q;
    assign out_if.word_idx   = word_q;
    assign out_if.first      = valid_c && (share_q == '0) && (word_q == '0);
    assign out_if.last_word  = last_word_c;
    assign out_if.last_share = last_share_c;
    assign out_if.last       = last_c;
endmodule

// File: tb/tb_serial_shares_words_sequencer.sv
// Bench for serial_shares_words_sequencer: a queue-of-pairs reference model checked every cycle,
// plus directed scenarios with literal transfer sequences and latencies.
module tb_serial_shares_words_sequencer;
  localparam int NBITS = 4;
  localparam int MAXW  = 8;
  localparam int D     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [NBITS-1:0] bound;
  logic             word_major;
  logic             busy;
  logic             done;
  logic             dbg_state;

  serial_shares_words_sequencer_if #(.NBITS(NBITS)) sif ();

  serial_shares_words_sequencer #(
    .NBITS(NBITS), .MAX_WORDS_PER_SHARE(MAXW), .d(D)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .words_per_share_bound(bound), .word_major(word_major),
    .busy(busy), .done(done), .dbg_state(dbg_state), .out_if(sif.master)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: the whole remaining sequence as a queue of {share,word}
  logic [2*NBITS-1:0] exp_q[$];
  logic               m_busy = 1'b0;
  logic               m_done = 1'b0;
  int                 m_b    = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start && !abort) begin
          m_busy = 1'b1;
          m_b = (int'(bound) > MAXW - 1) ? MAXW - 1 : int'(bound);
          exp_q.delete();
          if (!word_major) begin
            for (int s = 0; s < D; s++)
              for (int w = 0; w <= m_b; w++) exp_q.push_back({NBITS'(s), NBITS'(w)});
          end else begin
            for (int w = 0; w <= m_b; w++)
              for (int s = 0; s < D; s++) exp_q.push_back({NBITS'(s), NBITS'(w)});
          end
        end
      end else if (abort) begin
        m_busy = 1'b0;
        exp_q.delete();
      end else if (sif.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  // scoreboard compare on the falling edge, plus log of observed transfers
  logic [2*NBITS-1:0] xfer_log[$];

  always @(negedge clk) begin
    logic [2*NBITS-1:0] p;
    p = (m_busy && exp_q.size() > 0) ? exp_q[0] : '0;
    chk("valid", sif.out_valid, m_busy);
    chk("busy", busy, m_busy);
    chk("state", dbg_state, m_busy);
    chk("done", done, m_done);
    chk("share_idx", sif.share_idx, p[2*NBITS-1:NBITS]);
    chk("word_idx", sif.word_idx, p[NBITS-1:0]);
    chk("first", sif.first, m_busy && p == '0);
    chk("last_word", sif.last_word, m_busy && int'(p[NBITS-1:0]) == m_b);
    chk("last_share", sif.last_share, m_busy && int'(p[2*NBITS-1:NBITS]) == D - 1);
    chk("last", sif.last, m_busy && exp_q.size() == 1);
    if (done) done_count++;
    if (sif.out_valid && sif.out_ready) xfer_log.push_back({sif.share_idx, sif.word_idx});
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_seq(input logic [NBITS-1:0] b, input logic wm);
    start = 1'b1;
    bound = b;
    word_major = wm;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      tick();
      cycles++;
    end
    if (!done) chk("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic chk_log(input string name, input logic [2*NBITS-1:0] exp[]);
    chk({name, "_len"}, xfer_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < xfer_log.size(); i++) chk(name, xfer_log[i], exp[i]);
  endtask

  initial begin
    int cyc;
    int dc;
    logic [2*NBITS-1:0] t1_exp[] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13};
    logic [2*NBITS-1:0] t2_exp[] = '{8'h00, 8'h10, 8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13};
    logic [2*NBITS-1:0] t4_exp[] = '{8'h00, 8'h10};

    rst = 1'b1; start = 1'b0; abort = 1'b0; bound = '0; word_major = 1'b0;
    sif.out_ready = 1'b1;
    tick(); tick(); tick();
    chk("reset_valid", sif.out_valid, 1'b0);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;
    tick();

    // T1 share-major, bound 3, start-to-done = 1 + 2*4 cycles
    xfer_log.delete();
    start_seq(4'd3, 1'b0);
    chk("t1_first", sif.first, 1'b1);
    wait_done(40, cyc);
    chk("t1_latency", cyc + 1, 9);
    chk_log("t1_seq", t1_exp);

    // T6 start in the done cycle, word-major run (T2)
    xfer_log.delete();
    start_seq(4'd3, 1'b1);
    chk("t6_valid", sif.out_valid, 1'b1);
    chk("t6_pair", {sif.share_idx, sif.word_idx}, 8'h00);
    wait_done(40, cyc);
    chk("t2_latency", cyc + 1, 9);
    chk_log("t2_seq", t2_exp);
    tick();

    // T3 bound clamped 15 -> 7, random ready
    xfer_log.delete();
    start_seq(4'd15, 1'b0);
    cyc = 0;
    while (!done && cyc < 300) begin
      sif.out_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    if (!done) chk("t3_timeout", 1'b0, 1'b1);
    sif.out_ready = 1'b1;
    chk("t3_len", xfer_log.size(), 16);
    if (xfer_log.size() == 16) begin
      chk("t3_mid", xfer_log[7], 8'h07);
      chk("t3_end", xfer_log[15], 8'h17);
    end
    tick();

    // T4 bound 0: two pairs, both last_word
    xfer_log.delete();
    start_seq(4'd0, 1'b0);
    chk("t4_last_word", sif.last_word, 1'b1);
    chk("t4_last_early", sif.last, 1'b0);
    wait_done(20, cyc);
    chk("t4_latency", cyc + 1, 3);
    chk_log("t4_seq", t4_exp);
    tick();

    // T5 start ignored mid-run, rst at pair 3, abort at pair 5
    start_seq(4'd3, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_pair2", {sif.share_idx, sif.word_idx}, 8'h01);
    tick();
    chk("t5_pair3", {sif.share_idx, sif.word_idx}, 8'h02);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_valid", sif.out_valid, 1'b0);
    chk("t5_rst_idx", {sif.share_idx, sif.word_idx}, 8'h00);
    tick();
    start_seq(4'd3, 1'b0);
    tick(); tick(); tick(); tick();
    chk("t5_pair5", {sif.share_idx, sif.word_idx}, 8'h10);
    dc = done_count;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t5_abort_busy", busy, 1'b0);
    tick(); tick();
    chk("t5_no_done", done_count, dc);

    // abort in IDLE blocks a simultaneous start
    abort = 1'b1; start_seq(4'd3, 1'b0); abort = 1'b0;
    chk("idle_abort_blocks", sif.out_valid, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
